// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, next-PC selection, misaligned-target
// trap handling and cycle/instret counters for the single-cycle core.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              IALIGN       = 4,
    parameter int              HALT_ON_TRAP = 0,
    parameter int              CNT_WIDTH    = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch,
    input  logic                 cond,
    input  logic                 jump,
    input  logic                 jalr,
    input  logic [XLEN-1:0]      imm_ext,
    input  logic [XLEN-1:0]      rs1_val,
    output logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      pc_plus_4,
    output logic [XLEN-1:0]      pc_target,
    output logic                 trap,
    output logic [XLEN-1:0]      mepc,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);

    localparam logic [XLEN-1:0]      PC_STEP = XLEN'(4);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic [XLEN-1:0]      mepc_q, mepc_d;
    logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
    logic [CNT_WIDTH-1:0] ret_q, ret_d;

    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_tgt;
    logic [XLEN-1:0] next_pc;
    logic            taken;
    logic            misaligned;
    logic            in_run;

    always_comb begin
        pc_plus_4 = pc_q + PC_STEP;
        pc_target = pc_q + imm_ext;
        jalr_sum  = rs1_val + imm_ext;
        jalr_tgt  = {jalr_sum[XLEN-1:1], 1'b0};
        taken     = jalr | jump | (branch & cond);
        in_run    = (state_q == S_RUN);

        if (jalr) begin
            next_pc = jalr_tgt;
        end else if (jump || (branch && cond)) begin
            next_pc = pc_target;
        end else begin
            next_pc = pc_plus_4;
        end

        // Only a taken redirect can be misaligned; PC+4 is always aligned.
        if (IALIGN == 2) begin
            misaligned = next_pc[0];
        end else begin
            misaligned = (next_pc[1:0] != 2'b00);
        end

        trap = in_run & taken & misaligned;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mepc_d  = mepc_q;
        cyc_d   = cyc_q;
        ret_d   = ret_q;

        unique case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                cyc_d = cyc_q + CNT_ONE;
                if (!stall) begin
                    if (trap) begin
                        mepc_d = pc_q;
                        if (HALT_ON_TRAP != 0) begin
                            state_d = S_HALT;
                        end else begin
                            pc_d = TRAP_VECTOR;
                        end
                    end else begin
                        pc_d  = next_pc;
                        ret_d = ret_q + CNT_ONE;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VECTOR;
            mepc_q  <= '0;
            cyc_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mepc_q  <= mepc_d;
            cyc_q   <= cyc_d;
            ret_q   <= ret_d;
        end
    end

    assign pc            = pc_q;
    assign mepc          = mepc_q;
    assign halted        = (state_q == S_HALT);
    assign cycle_count   = cyc_q;
    assign instret_count = ret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: three instances with different
// alignment / trap / counter-width parameters share one stimulus stream.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch;
    logic        cond;
    logic        jump;
    logic        jalr;
    logic [31:0] imm_ext;
    logic [31:0] rs1_val;

    logic [31:0] a_pc, a_p4, a_tgt, a_mepc;
    logic        a_trap, a_halted;
    logic [63:0] a_cyc, a_ret;

    logic [31:0] b_pc, b_p4, b_tgt, b_mepc;
    logic        b_trap, b_halted;
    logic [3:0]  b_cyc, b_ret;

    logic [31:0] c_pc, c_p4, c_tgt, c_mepc;
    logic        c_trap, c_halted;
    logic [63:0] c_cyc, c_ret;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_sequencer u_a (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch),
        .cond(cond), .jump(jump), .jalr(jalr), .imm_ext(imm_ext),
        .rs1_val(rs1_val), .pc(a_pc), .pc_plus_4(a_p4),
        .pc_target(a_tgt), .trap(a_trap), .mepc(a_mepc),
        .halted(a_halted), .cycle_count(a_cyc), .instret_count(a_ret)
    );

    pc_sequencer #(.IALIGN(2), .CNT_WIDTH(4)) u_b (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch),
        .cond(cond), .jump(jump), .jalr(jalr), .imm_ext(imm_ext),
        .rs1_val(rs1_val), .pc(b_pc), .pc_plus_4(b_p4),
        .pc_target(b_tgt), .trap(b_trap), .mepc(b_mepc),
        .halted(b_halted), .cycle_count(b_cyc), .instret_count(b_ret)
    );

    pc_sequencer #(.HALT_ON_TRAP(1)) u_c (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch),
        .cond(cond), .jump(jump), .jalr(jalr), .imm_ext(imm_ext),
        .rs1_val(rs1_val), .pc(c_pc), .pc_plus_4(c_p4),
        .pc_target(c_tgt), .trap(c_trap), .mepc(c_mepc),
        .halted(c_halted), .cycle_count(c_cyc), .instret_count(c_ret)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; branch = 0; cond = 0; jump = 0; jalr = 0;
        imm_ext = '0; rs1_val = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (a_pc !== 32'h0) begin
            errors++; $display("FAIL reset_pc got=%h exp=%h", a_pc, 32'h0);
        end
        checks++;
        if (a_mepc !== 32'h0 || a_halted !== 1'b0 || c_halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_misc mepc=%h halted=%b/%b exp=0/0/0",
                     a_mepc, a_halted, c_halted);
        end
        checks++;
        if (a_cyc !== 64'd0 || a_ret !== 64'd0) begin
            errors++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", a_cyc, a_ret);
        end
        step();
        checks++;
        if (a_pc !== 32'h0 || a_cyc !== 64'd0) begin
            errors++;
            $display("FAIL boot_hold pc=%h cyc=%0d exp=0/0", a_pc, a_cyc);
        end
        step();
        checks++;
        if (a_pc !== 32'h4) begin
            errors++; $display("FAIL seq_4 got=%h exp=%h", a_pc, 32'h4);
        end
        step();
        step();
        checks++;
        if (a_pc !== 32'hC || a_cyc !== 64'd3 || a_ret !== 64'd3) begin
            errors++;
            $display("FAIL seq_12 pc=%h cyc=%0d ret=%0d exp=c/3/3",
                     a_pc, a_cyc, a_ret);
        end
        checks++;
        if (a_p4 !== 32'h10) begin
            errors++; $display("FAIL pc_plus_4 got=%h exp=%h", a_p4, 32'h10);
        end
    endtask

    task automatic test_branch();
        step();
        branch = 1; cond = 1; imm_ext = 32'hFFFF_FFF8;
        #1;
        checks++;
        if (a_tgt !== 32'h8 || a_trap !== 1'b0) begin
            errors++;
            $display("FAIL br_target got=%h trap=%b exp=8/0", a_tgt, a_trap);
        end
        step();
        checks++;
        if (a_pc !== 32'h8) begin
            errors++; $display("FAIL br_taken got=%h exp=%h", a_pc, 32'h8);
        end
        idle();
        step();
        step();
        branch = 1; cond = 0; imm_ext = 32'hFFFF_FFF8;
        step();
        checks++;
        if (a_pc !== 32'h14) begin
            errors++; $display("FAIL br_not_taken got=%h exp=%h", a_pc, 32'h14);
        end
        idle();
        jump = 1; imm_ext = 32'hFFFF_FFFC;
        step();
        imm_ext = 32'h20;
        step();
        checks++;
        if (a_pc !== 32'h30 || a_ret !== 64'd10) begin
            errors++;
            $display("FAIL jal got=%h ret=%0d exp=30/10", a_pc, a_ret);
        end
        idle();
    endtask

    task automatic test_jalr();
        jalr = 1; jump = 1; rs1_val = 32'h200; imm_ext = 32'h10;
        step();
        checks++;
        if (a_pc !== 32'h210) begin
            errors++; $display("FAIL jalr_prio got=%h exp=%h", a_pc, 32'h210);
        end
        jump = 0; rs1_val = 32'h1001; imm_ext = 32'h2;
        #1;
        checks++;
        if (a_trap !== 1'b1 || b_trap !== 1'b0) begin
            errors++;
            $display("FAIL jalr_trap_flag got=%b/%b exp=1/0", a_trap, b_trap);
        end
        step();
        checks++;
        if (a_pc !== 32'h100 || a_mepc !== 32'h210) begin
            errors++;
            $display("FAIL jalr_trap pc=%h mepc=%h exp=100/210", a_pc, a_mepc);
        end
        checks++;
        if (a_ret !== 64'd11 || a_cyc !== 64'd12) begin
            errors++;
            $display("FAIL jalr_trap_cnt ret=%0d cyc=%0d exp=11/12", a_ret, a_cyc);
        end
        checks++;
        if (b_pc !== 32'h1002 || b_ret !== 4'd12) begin
            errors++;
            $display("FAIL jalr_ialign2 pc=%h ret=%0d exp=1002/12", b_pc, b_ret);
        end
        checks++;
        if (c_halted !== 1'b1 || c_pc !== 32'h210) begin
            errors++;
            $display("FAIL jalr_halt halted=%b pc=%h exp=1/210", c_halted, c_pc);
        end
        idle();
    endtask

    task automatic test_halt();
        do_reset();
        step();
        jump = 1; imm_ext = 32'h40;
        step();
        imm_ext = 32'h6;
        #1;
        checks++;
        if (c_trap !== 1'b1) begin
            errors++; $display("FAIL halt_trap_flag got=%b exp=1", c_trap);
        end
        step();
        checks++;
        if (c_halted !== 1'b1 || c_pc !== 32'h40 || c_mepc !== 32'h40) begin
            errors++;
            $display("FAIL halt_enter halted=%b pc=%h mepc=%h exp=1/40/40",
                     c_halted, c_pc, c_mepc);
        end
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (c_cyc !== 64'd2 || c_ret !== 64'd1 || c_pc !== 32'h40) begin
            errors++;
            $display("FAIL halt_frozen cyc=%0d ret=%0d pc=%h exp=2/1/40",
                     c_cyc, c_ret, c_pc);
        end
        checks++;
        if (c_trap !== 1'b0) begin
            errors++; $display("FAIL halt_no_trap got=%b exp=0", c_trap);
        end
        reset = 1;
        step();
        reset = 0;
        checks++;
        if (c_pc !== 32'h0 || c_halted !== 1'b0 || c_mepc !== 32'h0) begin
            errors++;
            $display("FAIL halt_reset pc=%h halted=%b mepc=%h exp=0/0/0",
                     c_pc, c_halted, c_mepc);
        end
        idle();
    endtask

    task automatic test_stall();
        do_reset();
        step();
        jump = 1; imm_ext = 32'h20;
        step();
        idle();
        stall = 1; branch = 1; cond = 1; imm_ext = 32'h10;
        step();
        step();
        step();
        checks++;
        if (a_pc !== 32'h20 || a_cyc !== 64'd4 || a_ret !== 64'd1) begin
            errors++;
            $display("FAIL stall_hold pc=%h cyc=%0d ret=%0d exp=20/4/1",
                     a_pc, a_cyc, a_ret);
        end
        stall = 0;
        step();
        checks++;
        if (a_pc !== 32'h30 || a_ret !== 64'd2) begin
            errors++;
            $display("FAIL stall_release pc=%h ret=%0d exp=30/2", a_pc, a_ret);
        end
        idle();
        stall = 1; jump = 1; imm_ext = 32'h2;
        #1;
        checks++;
        if (a_trap !== 1'b1) begin
            errors++; $display("FAIL stall_trap_flag got=%b exp=1", a_trap);
        end
        step();
        checks++;
        if (a_pc !== 32'h30 || a_mepc !== 32'h0) begin
            errors++;
            $display("FAIL stall_trap_hold pc=%h mepc=%h exp=30/0", a_pc, a_mepc);
        end
        stall = 0;
        step();
        checks++;
        if (a_pc !== 32'h100 || a_mepc !== 32'h30 || a_cyc !== 64'd7) begin
            errors++;
            $display("FAIL stall_trap_take pc=%h mepc=%h cyc=%0d exp=100/30/7",
                     a_pc, a_mepc, a_cyc);
        end
        checks++;
        if (b_pc !== 32'h32 || b_trap !== 1'b0) begin
            errors++;
            $display("FAIL stall_ialign2 pc=%h trap=%b exp=32/0", b_pc, b_trap);
        end
        idle();
    endtask

    task automatic test_wrap();
        jalr = 1; rs1_val = 32'hFFFF_FFFC; imm_ext = 32'h0;
        step();
        idle();
        imm_ext = 32'h8;
        #1;
        checks++;
        if (a_pc !== 32'hFFFF_FFFC || a_p4 !== 32'h0 || a_tgt !== 32'h4) begin
            errors++;
            $display("FAIL wrap_comb pc=%h p4=%h tgt=%h exp=fffffffc/0/4",
                     a_pc, a_p4, a_tgt);
        end
        step();
        checks++;
        if (a_pc !== 32'h0) begin
            errors++; $display("FAIL pc_wrap got=%h exp=%h", a_pc, 32'h0);
        end
        idle();
        do_reset();
        step();
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (b_cyc !== 4'd15 || b_ret !== 4'd15) begin
            errors++;
            $display("FAIL cnt_pre_wrap cyc=%0d ret=%0d exp=15/15", b_cyc, b_ret);
        end
        step();
        checks++;
        if (b_cyc !== 4'd0 || b_ret !== 4'd0 || a_cyc !== 64'd16) begin
            errors++;
            $display("FAIL cnt_wrap cyc=%0d ret=%0d acyc=%0d exp=0/0/16",
                     b_cyc, b_ret, a_cyc);
        end
    endtask

    task automatic test_reset_priority();
        stall = 1; jump = 1; imm_ext = 32'h20; reset = 1;
        step();
        reset = 0;
        idle();
        checks++;
        if (a_pc !== 32'h0 || a_cyc !== 64'd0 || a_ret !== 64'd0) begin
            errors++;
            $display("FAIL reset_prio pc=%h cyc=%0d ret=%0d exp=0/0/0",
                     a_pc, a_cyc, a_ret);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_branch();
        test_jalr();
        test_halt();
        test_stall();
        test_wrap();
        test_reset_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle RISC-V core: holds the architectural PC register and computes PC+4 and the PC-relative target internally. Selects the next PC from sequential, branch/JAL target, or JALR target. Detects misaligned control-transfer targets and either redirects to a trap vector or halts. Maintains cycle and retired-instruction counters. Sits between the control unit/ALU outputs and the instruction memory address port, and supplies pc_plus_4 and pc_target to the writeback select.

## Interface
- XLEN, 32, PC and data width
- RESET_VECTOR, 32'h0000_0000, PC loaded by reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned-target trap
- IALIGN, 4, instruction alignment in bytes; 4 or 2
- HALT_ON_TRAP, 0, 1 = enter HALT on trap instead of redirecting
- CNT_WIDTH, 64, width of the cycle and instret counters

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC; current instruction does not retire
- branch  in  1  instruction is a conditional branch
- cond  in  1  branch condition true (ALU zero/compare)
- jump  in  1  instruction is JAL
- jalr  in  1  instruction is JALR
- imm_ext  in  XLEN  sign-extended immediate
- rs1_val  in  XLEN  rs1 operand for JALR
- pc  out  XLEN  current PC (instruction memory address)
- pc_plus_4  out  XLEN  pc + 4, combinational
- pc_target  out  XLEN  pc + imm_ext, combinational
- trap  out  1  combinational: a misaligned taken target exists this cycle (in RUN)
- mepc  out  XLEN  PC of the last trapping instruction
- halted  out  1  high in HALT state
- cycle_count  out  CNT_WIDTH  cycles spent in RUN
- instret_count  out  CNT_WIDTH  retired instructions

## Operation
- States: BOOT, RUN, HALT. Reset forces BOOT. BOOT -> RUN unconditionally on the next clock. RUN -> HALT on trap when HALT_ON_TRAP=1. HALT is left only by reset.
- Reset values: pc=RESET_VECTOR, mepc=0, cycle_count=0, instret_count=0, halted=0, state=BOOT.
- Target selection, with priority jalr > jump > (branch & cond) > sequential:
  - jalr: next = (rs1_val + imm_ext) & ~1.
  - jump, or branch & cond: next = pc_target.
  - otherwise: next = pc_plus_4.
- All additions are modulo 2^XLEN; the carry is discarded.
- Misalignment is checked only when a taken redirect is selected. IALIGN=4: next[1:0]!=0. IALIGN=2: next[0]!=0, which never fires for jalr because bit 0 is cleared. Sequential PC is never checked.
- In RUN with stall=0 and no trap: pc<=next, instret_count+=1.
- In RUN with stall=0 and trap: mepc<=pc and instret_count is unchanged.
  - HALT_ON_TRAP=0: pc<=TRAP_VECTOR.
  - HALT_ON_TRAP=1: pc holds and the state moves to HALT.
- In RUN with stall=1: pc, mepc and instret_count hold, and trap is still reported. A stalled trap takes effect only on the first unstalled cycle.
- cycle_count increments every RUN cycle, stalled or not. It holds in BOOT and HALT.
- Both counters wrap to 0 at 2^CNT_WIDTH.
- In BOOT and HALT, pc holds and trap=0; all control inputs are ignored.

## Timing
- pc_plus_4, pc_target and trap are combinational from pc and the inputs.
- pc, mepc, the counters and halted update on the rising clk edge. A redirect is visible on pc one cycle after the instruction that caused it.
- Reset is synchronous: asserting it mid-operation takes effect at the next edge and overrides stall, trap and any redirect. The first instruction fetched after reset is at RESET_VECTOR, and it executes in the RUN cycle after BOOT.
- Reset asserted in HALT returns to BOOT. mepc is cleared.
- jalr and jump asserted together: jalr wins.

## Test plan
- Reset then free-run, RESET_VECTOR=0: pc sequence 0, 0 (BOOT), 4, 8, 12. After 3 RUN cycles, instret_count=3 and cycle_count=3.
- At pc=0x10, branch=1, cond=1, imm_ext=0xFFFF_FFF8: next pc=0x08. With cond=0: next pc=0x14. JAL with imm=0x20 at pc=0x10: next pc=0x30.
- JALR with rs1_val=0x1001, imm_ext=2: IALIGN=2 gives pc=0x1002 with no trap. IALIGN=4 gives trap=1, mepc=old pc, pc=0x100, and instret_count unchanged.
- HALT_ON_TRAP=1, jump at pc=0x40 with imm=6:
  - trap gives halted=1 and pc stays 0x40.
  - For 10 cycles, cycle_count and instret_count stay frozen.
  - Reset then gives pc=RESET_VECTOR and halted=0.
- stall held 3 cycles at pc=0x20 with a taken branch pending: pc stays 0x20, cycle_count +3, instret_count +0. Releasing stall gives redirect on the next edge.
- pc=0xFFFF_FFFC sequential gives pc=0 (wrap). CNT_WIDTH=4: cycle_count wraps 15 to 0. Reset asserted together with stall and a redirect gives pc=RESET_VECTOR.
